// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N_REQ producers, the round-robin arbiter and the FIFO
// write port. master = producers/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
);
  localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        accept;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_data_in;
  logic [OWNER_W-1:0]      owner;
  logic                    busy;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  gnt, accept, fifo_wr_en, fifo_data_in, owner, busy
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output gnt, accept, fifo_wr_en, fifo_data_in, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers; a grant
// lasts up to MAX_BURST beats and stalls, without losing its place, while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [N_REQ-1:0]   gnt;
  logic [OWNER_W-1:0] owner;
  logic [OWNER_W-1:0] last_owner;
  logic [3:0]         cnt;
  logic               busy;

  logic               beat;
  logic               release_now;
  logic [OWNER_W-1:0] win;

  // First requester at or after last_owner+1, wrapping; indices >= N_REQ never scanned.
  function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [OWNER_W-1:0] last);
    logic [OWNER_W-1:0] w;
    logic               found;
    int                 idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = OWNER_W'(idx);
      end
    end
    return w;
  endfunction

  assign win  = rr_pick(bus.req, last_owner);
  assign beat = rst && (state == GRANT) && bus.req[owner] && !bus.fifo_full;

  // A dropped request releases even while the FIFO is full.
  assign release_now = (beat && (bus.req_last[owner] || (cnt + 4'd1) == 4'(MAX_BURST)))
                    || !bus.req[owner];

  assign bus.fifo_wr_en   = beat;
  assign bus.accept       = beat ? gnt : '0;
  assign bus.fifo_data_in = (state == GRANT) ? bus.req_data[int'(owner)*DATA_W +: DATA_W]
                                             : '0;
  assign bus.gnt          = gnt;
  assign bus.owner        = owner;
  assign bus.busy         = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= OWNER_W'(N_REQ - 1);
      cnt        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state      <= GRANT;
            gnt        <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            owner      <= win;
            last_owner <= win;
            cnt        <= '0;
            busy       <= 1'b1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (beat) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
